pc_update_unit: RTL and testbench
=================================

// Module: pc_update_unit
// PURPOSE
//  Program-counter register stage fed by the PC-source mux output. Commits the next PC
//  on unconditional or condition-qualified writes (beq/bne/blt/bgt), and runs the
//  exception sequence: saves EPC, fetches the handler byte from a fixed memory vector
//  and loads it into the PC. Sits between the PC-source mux and the instruction memory.
// PARAMETERS
//  WIDTH     32   datapath width of pc, epc, pc_next_in, mem_addr, mem_rdata
//  RESET_PC  0    PC value after reset
//  VEC_BASE  253  memory address of the cause-0 handler byte; cause n reads VEC_BASE+n
//  MEM_LAT   1    memory read latency in cycles, >=1; mem_rdata valid in last WAIT cycle
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  pc_next_in     in   WIDTH  next-PC candidate from the PC-source mux
//  pc_write       in   1      unconditional PC write
//  pc_write_cond  in   1      PC write qualified by branch_type and ALU flags
//  branch_type    in   2      00 beq(zero), 01 bne(!zero), 10 blt(lt), 11 bgt(gt)
//  alu_zero       in   1      ALU zero flag
//  alu_lt         in   1      ALU less-than flag
//  alu_gt         in   1      ALU greater-than flag
//  exc_req        in   1      exception request, sampled in IDLE only
//  exc_cause      in   2      00 invalid opcode, 01 overflow, 10 div-by-zero, 11 -> as 00
//  mem_rdata      in   WIDTH  memory read data; handler address = zero-extended [7:0]
//  pc             out  WIDTH  current program counter (registered)
//  epc            out  WIDTH  exception PC (registered)
//  mem_req        out  1      memory read request for handler byte
//  mem_addr       out  WIDTH  handler byte address, VEC_BASE+cause while mem_req=1, else 0
//  busy           out  1      high whenever state != IDLE
//  exc_done       out  1      one-cycle pulse after the handler address is loaded into pc
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, epc=0, state=IDLE, wait counter=0,
//   latched cause=0, mem_req=0, mem_addr=0, busy=0, exc_done=0.
//   Reset mid-sequence aborts it; pc does not take the handler address.
//  States: IDLE, REQ, WAIT, LOAD.
//  IDLE:
//   exc_req=1: epc<=pc-4 (mod 2^WIDTH), cause latched (11->00), ->REQ.
//    pc is not written this cycle, even if pc_write/pc_write_cond=1 (exception wins).
//   else if pc_write=1, or pc_write_cond=1 and cond true: pc<=pc_next_in.
//    cond: 00 alu_zero, 01 !alu_zero, 10 alu_lt, 11 alu_gt.
//   else pc holds.
//  REQ: 1 cycle, mem_req=1, mem_addr=VEC_BASE+cause; load counter with MEM_LAT; ->WAIT.
//  WAIT: mem_req, mem_addr held; counter decrements each cycle;
//   in the last WAIT cycle (counter==1) capture mem_rdata[7:0] -> LOAD.
//  LOAD: pc<={0,captured byte}; mem_req=0; ->IDLE; exc_done=1 in the first IDLE cycle.
//  busy=1 in REQ/WAIT/LOAD. pc_write, pc_write_cond, exc_req are ignored while busy.
//   A new exc_req is accepted in the IDLE cycle right after exc_done.
//  Latency, exc_req accepted in cycle T: mem_req high T+1..T+1+MEM_LAT,
//   pc updated at end of T+2+MEM_LAT, exc_done high in T+3+MEM_LAT.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  reset asserted mid-WAIT with RESET_PC=0 -> pc=0, epc=0, busy=0, mem_req=0 at once.
//  pc=0x10, pc_write=1, pc_next_in=0x14 -> pc=0x14 next cycle.
//  pc_write_cond=1, branch_type=01, alu_zero=1, pc_next_in=0x80 -> pc unchanged.
//   Same with alu_zero=0 -> pc=0x80.
//  pc=0x40, exc_req=1, cause=01, MEM_LAT=1 -> epc=0x3C, mem_addr=254 for 2 cycles,
//   mem_rdata=0x8C -> pc=0x8C, then exc_done pulse, busy low.
//  pc=0, exc_req=1 with pc_write=1, pc_next_in=0x4 -> epc=0xFFFFFFFC, pc stays 0 until LOAD.
//  pc_write pulses while busy -> pc unchanged until LOAD.
//   Cause 11 -> mem_addr=253.

Source files
------------

// File: rtl/pc_update_unit_if.sv
// Signal bundle between the PC update unit and its environment
// (PC-source mux, ALU flags, exception logic and handler-vector memory).
interface pc_update_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_next_in;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       branch_type;
    logic             alu_zero;
    logic             alu_lt;
    logic             alu_gt;
    logic             exc_req;
    logic [1:0]       exc_cause;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             busy;
    logic             exc_done;

    modport slave (
        input  pc_next_in, pc_write, pc_write_cond, branch_type,
               alu_zero, alu_lt, alu_gt, exc_req, exc_cause, mem_rdata,
        output pc, epc, mem_req, mem_addr, busy, exc_done
    );

    modport master (
        output pc_next_in, pc_write, pc_write_cond, branch_type,
               alu_zero, alu_lt, alu_gt, exc_req, exc_cause, mem_rdata,
        input  pc, epc, mem_req, mem_addr, busy, exc_done
    );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter register with branch-qualified writes and an exception
// sequence that saves EPC and loads the handler byte from a memory vector.
module pc_update_unit #(
    parameter int WIDTH    = 32,
    parameter int RESET_PC = 0,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    pc_update_unit_if.slave bus
);
    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] epc_reg, epc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       cause_reg, cause_next;
    logic [7:0]       byte_reg, byte_next;
    logic             mem_req_reg, mem_req_next;
    logic [WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic             busy_reg, busy_next;
    logic             exc_done_reg, exc_done_next;
    logic             cond_true;
    logic             unused_rdata;

    // Only the low byte of the vector entry is a handler address.
    assign unused_rdata = ^bus.mem_rdata[WIDTH-1:8];

    always_comb begin
        cond_true = 1'b0;
        case (bus.branch_type)
            2'b00:   cond_true = bus.alu_zero;
            2'b01:   cond_true = ~bus.alu_zero;
            2'b10:   cond_true = bus.alu_lt;
            default: cond_true = bus.alu_gt;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        cnt_next   = cnt_reg;
        cause_next = cause_reg;
        byte_next  = byte_reg;

        case (state_reg)
            S_IDLE: begin
                // An exception in the same cycle as a PC write wins.
                if (bus.exc_req) begin
                    epc_next   = pc_reg - WIDTH'(4);
                    cause_next = (bus.exc_cause == 2'b11) ? 2'b00 : bus.exc_cause;
                    state_next = S_REQ;
                end else if (bus.pc_write || (bus.pc_write_cond && cond_true)) begin
                    pc_next = bus.pc_next_in;
                end
            end
            S_REQ: begin
                cnt_next   = CNT_W'(MEM_LAT);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    byte_next  = bus.mem_rdata[7:0];
                    state_next = S_LOAD;
                end
            end
            default: begin
                pc_next    = WIDTH'(byte_reg);
                state_next = S_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they can be registered.
        mem_req_next  = (state_next == S_REQ) || (state_next == S_WAIT);
        mem_addr_next = mem_req_next ? (WIDTH'(VEC_BASE) + WIDTH'(cause_next)) : '0;
        busy_next     = (state_next != S_IDLE);
        exc_done_next = (state_reg == S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            pc_reg       <= WIDTH'(RESET_PC);
            epc_reg      <= '0;
            cnt_reg      <= '0;
            cause_reg    <= 2'b00;
            byte_reg     <= 8'h00;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            busy_reg     <= 1'b0;
            exc_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            epc_reg      <= epc_next;
            cnt_reg      <= cnt_next;
            cause_reg    <= cause_next;
            byte_reg     <= byte_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            busy_reg     <= busy_next;
            exc_done_reg <= exc_done_next;
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.epc      = epc_reg;
    assign bus.mem_req  = mem_req_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.busy     = busy_reg;
    assign bus.exc_done = exc_done_reg;
endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: a table of PC-write vectors plus
// hand-written exception, latency and mid-sequence reset sequences.
module tb_pc_update_unit;
    logic clk;
    logic reset1;
    logic reset3;
    int   checks;
    int   failures;

    pc_update_unit_if #(.WIDTH(32)) if1 ();
    pc_update_unit_if #(.WIDTH(32)) if3 ();

    pc_update_unit #(.WIDTH(32), .RESET_PC(0), .VEC_BASE(253), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (if1.slave)
    );

    pc_update_unit #(.WIDTH(32), .RESET_PC(32'h100), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (if3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pw;
        logic        pwc;
        logic [1:0]  bt;
        logic        z;
        logic        lt;
        logic        gt;
        logic [31:0] nxt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset1   = 1'b1;
        reset3   = 1'b1;
        if1.pc_next_in = '0; if1.pc_write = 0; if1.pc_write_cond = 0; if1.branch_type = 0;
        if1.alu_zero = 0; if1.alu_lt = 0; if1.alu_gt = 0; if1.exc_req = 0; if1.exc_cause = 0;
        if1.mem_rdata = '0;
        if3.pc_next_in = '0; if3.pc_write = 0; if3.pc_write_cond = 0; if3.branch_type = 0;
        if3.alu_zero = 0; if3.alu_lt = 0; if3.alu_gt = 0; if3.exc_req = 0; if3.exc_cause = 0;
        if3.mem_rdata = '0;

        //           pw   pwc  bt     z    lt   gt   nxt        exp_pc
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 32'h10};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h14, 32'h14};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h80, 32'h14};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h80, 32'h80};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h40, 32'h40};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'h44, 32'h40};
        vecs[6]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 32'h50, 32'h50};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 32'h54, 32'h50};
        vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 32'h60, 32'h60};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h64, 32'h60};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h70, 32'h60};
        vecs[11] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'h40, 32'h40};

        step();
        step();
        chk("rst_pc", if1.pc, 32'h0);
        chk("rst_epc", if1.epc, 32'h0);
        chk("rst_busy", 32'(if1.busy), 32'h0);
        chk("rst_mem_req", 32'(if1.mem_req), 32'h0);
        chk("rst_mem_addr", if1.mem_addr, 32'h0);
        chk("rst_exc_done", 32'(if1.exc_done), 32'h0);
        chk("rst3_pc", if3.pc, 32'h100);
        reset1 = 1'b0;
        reset3 = 1'b0;
        step();

        // Table of plain and condition-qualified PC writes.
        for (int i = 0; i < 12; i++) begin
            if1.pc_write      = vecs[i].pw;
            if1.pc_write_cond = vecs[i].pwc;
            if1.branch_type   = vecs[i].bt;
            if1.alu_zero      = vecs[i].z;
            if1.alu_lt        = vecs[i].lt;
            if1.alu_gt        = vecs[i].gt;
            if1.pc_next_in    = vecs[i].nxt;
            step();
            chk($sformatf("vec%0d_pc", i), if1.pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_busy", i), 32'(if1.busy), 32'h0);
            $display("vec %0d pw=%0b pwc=%0b bt=%0d nxt=0x%0h pc=0x%0h", i,
                     vecs[i].pw, vecs[i].pwc, vecs[i].bt, vecs[i].nxt, if1.pc);
        end
        if1.pc_write_cond = 1'b0;

        // Exception cause 01 from pc=0x40; PC writes during the sequence are ignored.
        if1.exc_req = 1'b1; if1.exc_cause = 2'b01;
        if1.pc_write = 1'b1; if1.pc_next_in = 32'h999; if1.mem_rdata = 32'h18C;
        step();
        chk("exc1_req_epc", if1.epc, 32'h3C);
        chk("exc1_req_pc", if1.pc, 32'h40);
        chk("exc1_req_mem_req", 32'(if1.mem_req), 32'h1);
        chk("exc1_req_addr", if1.mem_addr, 32'd254);
        chk("exc1_req_busy", 32'(if1.busy), 32'h1);
        if1.exc_req = 1'b0;
        step();
        chk("exc1_wait_mem_req", 32'(if1.mem_req), 32'h1);
        chk("exc1_wait_addr", if1.mem_addr, 32'd254);
        chk("exc1_wait_pc", if1.pc, 32'h40);
        step();
        chk("exc1_load_mem_req", 32'(if1.mem_req), 32'h0);
        chk("exc1_load_addr", if1.mem_addr, 32'h0);
        chk("exc1_load_busy", 32'(if1.busy), 32'h1);
        chk("exc1_load_pc", if1.pc, 32'h40);
        step();
        chk("exc1_done_pc", if1.pc, 32'h8C);
        chk("exc1_done_pulse", 32'(if1.exc_done), 32'h1);
        chk("exc1_done_busy", 32'(if1.busy), 32'h0);
        $display("exc1 cause=1 epc=0x%0h pc=0x%0h", if1.epc, if1.pc);

        // Back-to-back exception in the exc_done cycle, cause 11 aliases to 00.
        if1.exc_req = 1'b1; if1.exc_cause = 2'b11;
        if1.pc_next_in = 32'h4; if1.mem_rdata = 32'hFF00;
        step();
        chk("exc2_epc", if1.epc, 32'h88);
        chk("exc2_addr", if1.mem_addr, 32'd253);
        chk("exc2_pc", if1.pc, 32'h8C);
        chk("exc2_done_clear", 32'(if1.exc_done), 32'h0);
        if1.exc_req = 1'b0;
        step();
        step();
        chk("exc2_load_pc", if1.pc, 32'h8C);
        if1.pc_write = 1'b0;
        step();
        chk("exc2_done_pc", if1.pc, 32'h0);
        chk("exc2_done_pulse", 32'(if1.exc_done), 32'h1);
        $display("exc2 cause=3 epc=0x%0h pc=0x%0h", if1.epc, if1.pc);

        // Exception at pc=0 wraps epc; reset mid-WAIT aborts the handler load.
        if1.exc_req = 1'b1; if1.exc_cause = 2'b10;
        if1.pc_write = 1'b1; if1.pc_next_in = 32'h4; if1.mem_rdata = 32'h77;
        step();
        chk("exc3_epc", if1.epc, 32'hFFFFFFFC);
        chk("exc3_pc", if1.pc, 32'h0);
        chk("exc3_addr", if1.mem_addr, 32'd255);
        if1.exc_req = 1'b0; if1.pc_write = 1'b0;
        step();
        chk("exc3_wait_busy", 32'(if1.busy), 32'h1);
        #2 reset1 = 1'b1;
        #1;
        chk("arst_pc", if1.pc, 32'h0);
        chk("arst_epc", if1.epc, 32'h0);
        chk("arst_busy", 32'(if1.busy), 32'h0);
        chk("arst_mem_req", 32'(if1.mem_req), 32'h0);
        chk("arst_mem_addr", if1.mem_addr, 32'h0);
        @(negedge clk);
        reset1 = 1'b0;
        step();
        step();
        step();
        chk("post_rst_pc", if1.pc, 32'h0);
        chk("post_rst_busy", 32'(if1.busy), 32'h0);
        chk("post_rst_done", 32'(if1.exc_done), 32'h0);
        $display("exc3 reset mid-wait pc=0x%0h busy=%0b", if1.pc, if1.busy);

        // MEM_LAT=3 instance: cycle-by-cycle latency and capture in the last WAIT cycle.
        if3.exc_req = 1'b1; if3.exc_cause = 2'b10; if3.mem_rdata = 32'h11;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("lat3_k%0d_mem_req", k), 32'(if3.mem_req), (k <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("lat3_k%0d_addr", k), if3.mem_addr, (k <= 4) ? 32'd255 : 32'h0);
            chk($sformatf("lat3_k%0d_busy", k), 32'(if3.busy), (k <= 5) ? 32'h1 : 32'h0);
            chk($sformatf("lat3_k%0d_done", k), 32'(if3.exc_done), (k == 6) ? 32'h1 : 32'h0);
            chk($sformatf("lat3_k%0d_pc", k), if3.pc, (k >= 6) ? 32'h5A : 32'h100);
            chk($sformatf("lat3_k%0d_epc", k), if3.epc, 32'hFC);
            $display("lat3 k=%0d mem_req=%0b busy=%0b done=%0b pc=0x%0h", k,
                     if3.mem_req, if3.busy, if3.exc_done, if3.pc);
            if3.exc_req   = 1'b0;
            if3.mem_rdata = (k == 4) ? 32'h5A : 32'h11;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
